// File: rtl/handshake_receiver_sv_if.sv
// Handshake and stream signals shared by the CDC sender and the receiving endpoint.
// The master side drives the request/data and consumes the stream; the slave side is the receiver.
interface handshake_receiver_sv_if #(
  parameter int WORD_LENGTH = 8
);
  logic                   req;
  logic [WORD_LENGTH-1:0] data;
  logic                   ack;
  logic [WORD_LENGTH-1:0] rx_data;
  logic                   rx_valid;
  logic                   rx_ready;

  modport master (output req, data, rx_ready, input ack, rx_data, rx_valid);
  modport slave  (input req, data, rx_ready, output ack, rx_data, rx_valid);
endinterface

// File: rtl/handshake_receiver_sv.sv
// Destination-domain endpoint of a four-phase req/ack handshake: synchronizes req, captures the
// sender's word once per transfer, presents it on a valid/ready stream and returns ack.
module handshake_receiver_sv #(
  parameter int WORD_LENGTH = 8,
  parameter int STAGES      = 2,
  parameter int ACK_EARLY   = 0,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  handshake_receiver_sv_if.slave bus,
  output logic                   o_busy,
  output logic [COUNT_WIDTH-1:0] o_xfer_count
);

  if (WORD_LENGTH <= 0) begin : g_bad_word_length
    $error("handshake_receiver_sv: WORD_LENGTH must be > 0");
  end
  if (STAGES < 2) begin : g_bad_stages
    $error("handshake_receiver_sv: STAGES must be >= 2");
  end

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;
  logic [1:0]             r_state;
  logic                   r_ack;
  logic                   r_rx_valid;
  logic [WORD_LENGTH-1:0] r_rx_data;
  logic [COUNT_WIDTH-1:0] r_count;

  logic [1:0]             w_state_next;
  logic                   w_ack_next;
  logic                   w_rx_valid_next;
  logic [WORD_LENGTH-1:0] w_rx_data_next;
  logic [COUNT_WIDTH-1:0] w_count_next;
  logic                   w_req_s;
  logic                   w_consume;
  logic                   w_cap;

  assign w_req_s   = r_sync[STAGES-1];
  assign w_consume = r_rx_valid && bus.rx_ready;
  // A held word blocks a new capture unless it is being consumed at the same edge.
  assign w_cap     = (r_state == ST_IDLE) && w_req_s && (!r_rx_valid || bus.rx_ready);

  always_comb begin
    w_state_next    = r_state;
    w_ack_next      = r_ack;
    w_rx_valid_next = r_rx_valid;
    w_rx_data_next  = r_rx_data;
    w_count_next    = r_count;
    if ((ACK_EARLY != 0) && w_consume) begin
      w_rx_valid_next = 1'b0;
    end
    case (r_state)
      ST_IDLE: begin
        if (w_cap) begin
          w_rx_data_next  = bus.data;
          w_rx_valid_next = 1'b1;
          if (ACK_EARLY != 0) begin
            w_ack_next   = 1'b1;
            w_state_next = ST_ACK;
          end else begin
            w_state_next = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (w_consume) begin
          w_rx_valid_next = 1'b0;
          w_ack_next      = 1'b1;
          w_state_next    = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!w_req_s) begin
          w_ack_next   = 1'b0;
          w_count_next = r_count + 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_ack_next   = 1'b0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync     <= '0;
      r_state    <= ST_IDLE;
      r_ack      <= 1'b0;
      r_rx_valid <= 1'b0;
      r_rx_data  <= '0;
      r_count    <= '0;
    end else begin
      r_sync     <= {r_sync[STAGES-2:0], bus.req};
      r_state    <= w_state_next;
      r_ack      <= w_ack_next;
      r_rx_valid <= w_rx_valid_next;
      r_rx_data  <= w_rx_data_next;
      r_count    <= w_count_next;
    end
  end

  assign bus.ack      = r_ack;
  assign bus.rx_valid = r_rx_valid;
  assign bus.rx_data  = r_rx_data;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_xfer_count = r_count;

endmodule
